// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack engine: opcodes, FSM states and the ALU result record.
// The RPN_SATURATE_EN macro selects saturating arithmetic in rpn_alu.
package rpn_pkg;

    localparam int RPN_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_MUL  = 3'd5,
        OP_DUP  = 3'd6,
        OP_SWAP = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [RPN_WIDTH-1:0] value;
        logic                 ovf;
    } alu_res_t;

    function automatic logic is_arith(input op_t o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_MUL);
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational unsigned ALU computing A op B for ADD/SUB/MUL with overflow detect.
// Defining RPN_SATURATE_EN clamps overflowing results instead of wrapping them.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        value = b;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                ovf   = sum[WIDTH];
                value = sum[WIDTH-1:0];
`ifdef RPN_SATURATE_EN
                if (ovf) value = '1;
`endif
            end
            OP_SUB: begin
                ovf   = (a < b);
                value = a - b;
`ifdef RPN_SATURATE_EN
                if (ovf) value = '0;
`endif
            end
            OP_MUL: begin
                ovf   = |prod[2*WIDTH-1:WIDTH];
                value = prod[WIDTH-1:0];
`ifdef RPN_SATURATE_EN
                if (ovf) value = '1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN calculator core: register-array operand stack, ALU and IDLE->EXEC->WB sequencer.
// Arithmetic overflow behaviour is selected by RPN_SATURATE_EN (see rpn_alu).
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_err,
    output logic                       done,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err_ovf,
    output logic                       err_unf,
    output logic                       err_arith
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             arith_q, arith_d;
    logic             rej_unf_q, rej_unf_d;
    logic             rej_ovf_q, rej_ovf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             done_q, done_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
    logic             err_arith_q, err_arith_d;

    logic [DW-1:0]    tos_idx, nos_idx;
    logic [AW-1:0]    tos_a, nos_a, push_a;
    logic             full, accept;
    logic [WIDTH-1:0] alu_value;
    logic             alu_ovf;

    assign tos_idx = depth_q - DW'(1);
    assign nos_idx = depth_q - DW'(2);
    assign tos_a   = tos_idx[AW-1:0];
    assign nos_a   = nos_idx[AW-1:0];
    assign push_a  = depth_q[AW-1:0];
    assign full    = (depth_q == DW'(DEPTH));
    assign accept  = op_valid && (state_q == IDLE);

    assign tos       = (depth_q >= DW'(1)) ? stack_q[tos_a] : '0;
    assign nos       = (depth_q >= DW'(2)) ? stack_q[nos_a] : '0;
    assign depth     = depth_q;
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;
    assign err_arith = err_arith_q;

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a     (nos),
        .b     (tos),
        .op    (op_q),
        .value (alu_value),
        .ovf   (alu_ovf)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q == IDLE);
        done_d   = (state_q == WB);
    end

    // EXEC decides accept/reject and latches the ALU result; WB applies the stack effect.
    always_comb begin
        op_d        = op_q;
        din_d       = din_q;
        res_d       = res_q;
        arith_d     = arith_q;
        rej_unf_d   = rej_unf_q;
        rej_ovf_d   = rej_ovf_q;
        stack_d     = stack_q;
        depth_d     = depth_q;
        err_ovf_d   = clr_err ? 1'b0 : err_ovf_q;
        err_unf_d   = clr_err ? 1'b0 : err_unf_q;
        err_arith_d = clr_err ? 1'b0 : err_arith_q;

        if (accept) begin
            op_d  = op_t'(op);
            din_d = din;
        end

        if (state_q == EXEC) begin
            res_d   = alu_value;
            arith_d = alu_ovf && is_arith(op_q);
            case (op_q)
                OP_POP, OP_DUP:                  rej_unf_d = (depth_q < DW'(1));
                OP_ADD, OP_SUB, OP_MUL, OP_SWAP: rej_unf_d = (depth_q < DW'(2));
                default:                         rej_unf_d = 1'b0;
            endcase
            rej_ovf_d = ((op_q == OP_PUSH) || (op_q == OP_DUP)) && full;
        end

        if (state_q == WB) begin
            if (rej_unf_q) begin
                err_unf_d = 1'b1;
            end else if (rej_ovf_q) begin
                err_ovf_d = 1'b1;
            end else begin
                if (arith_q) err_arith_d = 1'b1;
                case (op_q)
                    OP_PUSH: begin
                        stack_d[push_a] = din_q;
                        depth_d         = depth_q + DW'(1);
                    end
                    OP_POP: depth_d = depth_q - DW'(1);
                    OP_DUP: begin
                        stack_d[push_a] = stack_q[tos_a];
                        depth_d         = depth_q + DW'(1);
                    end
                    OP_SWAP: begin
                        stack_d[tos_a] = stack_q[nos_a];
                        stack_d[nos_a] = stack_q[tos_a];
                    end
                    OP_ADD, OP_SUB, OP_MUL: begin
                        stack_d[nos_a] = res_q;
                        depth_d        = depth_q - DW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q        <= OP_NOP;
            din_q       <= '0;
            res_q       <= '0;
            arith_q     <= 1'b0;
            rej_unf_q   <= 1'b0;
            rej_ovf_q   <= 1'b0;
            stack_q     <= '{default: '0};
            depth_q     <= '0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            err_arith_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            din_q       <= din_d;
            res_q       <= res_d;
            arith_q     <= arith_d;
            rej_unf_q   <= rej_unf_d;
            rej_ovf_q   <= rej_ovf_d;
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            done_q      <= done_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            err_arith_q <= err_arith_d;
        end
    end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Self-checking bench for rpn_stack_engine (WIDTH=8, DEPTH=16) against a queue-based model.
// Compile with +define+RPN_SATURATE_EN to check the saturating variant.
module tb_rpn_stack_engine;

    localparam int W = 8;
    localparam int D = 16;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, MUL = 3'd5, DUP = 3'd6, SWAP = 3'd7;

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   op;
    logic [W-1:0] din;
    logic         clr_err;
    logic         done;
    logic [W-1:0] tos, nos;
    logic [4:0]   depth;
    logic         err_ovf, err_unf, err_arith;

    int tests = 0;
    int fails = 0;

    int unsigned m_stack[$];
    bit m_ovf, m_unf, m_arith;

    always #5 CLOCK_50 = ~CLOCK_50;

    rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .din       (din),
        .clr_err   (clr_err),
        .done      (done),
        .tos       (tos),
        .nos       (nos),
        .depth     (depth),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_arith (err_arith)
    );

    // Reference model: a calculator stack held as a queue, top at the back.
    task automatic model_op(input logic [2:0] o, input int unsigned d);
        int unsigned a, b, r;
        int sz;
        sz = m_stack.size();
        case (o)
            PUSH: if (sz == D) m_ovf = 1; else m_stack.push_back(d);
            POP:  if (sz < 1) m_unf = 1; else void'(m_stack.pop_back());
            DUP: begin
                if (sz < 1) m_unf = 1;
                else if (sz == D) m_ovf = 1;
                else m_stack.push_back(m_stack[sz-1]);
            end
            SWAP: begin
                if (sz < 2) m_unf = 1;
                else begin
                    b = m_stack.pop_back();
                    a = m_stack.pop_back();
                    m_stack.push_back(b);
                    m_stack.push_back(a);
                end
            end
            ADD, SUB, MUL: begin
                if (sz < 2) m_unf = 1;
                else begin
                    b = m_stack.pop_back();
                    a = m_stack.pop_back();
                    if (o == ADD) begin
                        r = a + b;
                        if (r > 255) begin
                            m_arith = 1;
`ifdef RPN_SATURATE_EN
                            r = 255;
`else
                            r = r % 256;
`endif
                        end
                    end else if (o == SUB) begin
                        if (a < b) begin
                            m_arith = 1;
`ifdef RPN_SATURATE_EN
                            r = 0;
`else
                            r = a + 256 - b;
`endif
                        end else r = a - b;
                    end else begin
                        r = a * b;
                        if (r > 255) begin
                            m_arith = 1;
`ifdef RPN_SATURATE_EN
                            r = 255;
`else
                            r = r % 256;
`endif
                        end
                    end
                    m_stack.push_back(r);
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [23:0] model_vec();
        int sz;
        logic [7:0] t, n;
        sz = m_stack.size();
        t = (sz >= 1) ? 8'(m_stack[sz-1]) : 8'd0;
        n = (sz >= 2) ? 8'(m_stack[sz-2]) : 8'd0;
        return {t, n, 5'(sz), m_ovf, m_unf, m_arith};
    endfunction

    task automatic apply_reset();
        RESET_N  = 1'b0;
        op_valid = 1'b0;
        op       = NOP;
        din      = '0;
        clr_err  = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        m_stack.delete();
        m_ovf = 0; m_unf = 0; m_arith = 0;
    endtask

    // Drives one handshake; lat = negedges from the accepting edge to the first one seeing done.
    task automatic do_op(input logic [2:0] o, input logic [7:0] d, output int lat);
        int n;
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        op = o; din = d; op_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        op_valid = 1'b0;
        din = 8'($urandom);
        lat = 0;
        while (lat < 10) begin
            @(negedge CLOCK_50);
            lat++;
            if (done) break;
        end
        if (!done) lat = 99;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge CLOCK_50);
        #1;
        clr_err = 1'b0;
        @(negedge CLOCK_50);
        m_ovf = 0; m_unf = 0; m_arith = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge CLOCK_50);
        tests++;
        if ({tos, nos, depth, err_ovf, err_unf, err_arith, done, op_ready} !== {24'h0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset_state: got tos=%0d nos=%0d depth=%0d errs=%b%b%b done=%b ready=%b, need all 0 and ready=1",
                     tos, nos, depth, err_ovf, err_unf, err_arith, done, op_ready);
        end
    endtask

    task automatic test_add_basic();
        logic [2:0] ops [3] = '{PUSH, PUSH, ADD};
        logic [7:0] ds  [3] = '{8'd5, 8'd3, 8'd0};
        int lat;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], ds[i], lat);
            model_op(ops[i], ds[i]);
            tests++;
            if (lat !== 3) begin
                fails++;
                $display("[TB] FAIL add_latency: op %0d done after %0d, need 3", i, lat);
            end
        end
        tests++;
        if ({tos, depth, err_ovf, err_unf, err_arith} !== {8'd8, 5'd1, 3'b000}) begin
            fails++;
            $display("[TB] FAIL add_result: got tos=%0d depth=%0d errs=%b%b%b, need tos=8 depth=1 errs=000",
                     tos, depth, err_ovf, err_unf, err_arith);
        end
        @(negedge CLOCK_50);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL done_pulse: done=%b one cycle after pulse, need 0", done);
        end
    endtask

    task automatic test_arith_overflow();
        int lat;
        logic [7:0] want;
`ifdef RPN_SATURATE_EN
        want = 8'd255;
`else
        want = 8'd44;
`endif
        apply_reset();
        do_op(PUSH, 8'd200, lat);
        do_op(PUSH, 8'd100, lat);
        do_op(ADD, 8'd0, lat);
        tests++;
        if ({tos, depth, err_arith, err_unf, err_ovf} !== {want, 5'd1, 3'b100}) begin
            fails++;
            $display("[TB] FAIL add_overflow: got tos=%0d depth=%0d arith=%b unf=%b ovf=%b, need tos=%0d depth=1 arith=1",
                     tos, depth, err_arith, err_unf, err_ovf, want);
        end
    endtask

    task automatic test_sub_borrow();
        int lat;
        logic [7:0] want;
`ifdef RPN_SATURATE_EN
        want = 8'd0;
`else
        want = 8'd252;
`endif
        apply_reset();
        do_op(PUSH, 8'd3, lat);
        do_op(PUSH, 8'd7, lat);
        do_op(SUB, 8'd0, lat);
        tests++;
        if ({tos, depth, err_arith} !== {want, 5'd1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL sub_borrow: got tos=%0d depth=%0d arith=%b, need tos=%0d depth=1 arith=1",
                     tos, depth, err_arith, want);
        end
        pulse_clr();
        tests++;
        if ({err_ovf, err_unf, err_arith} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL clr_err: got errs=%b%b%b, need 000", err_ovf, err_unf, err_arith);
        end
    endtask

    task automatic test_underflow();
        int lat;
        apply_reset();
        do_op(POP, 8'd0, lat);
        tests++;
        if ({err_unf, depth} !== {1'b1, 5'd0}) begin
            fails++;
            $display("[TB] FAIL pop_empty: got unf=%b depth=%0d, need unf=1 depth=0", err_unf, depth);
        end
        // clr_err held across the whole op: the rejection in WB must still leave the flag set.
        clr_err = 1'b1;
        do_op(PUSH, 8'd9, lat);
        do_op(ADD, 8'd0, lat);
        clr_err = 1'b0;
        tests++;
        if ({err_unf, tos, depth, err_arith} !== {1'b1, 8'd9, 5'd1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL add_underflow: got unf=%b tos=%0d depth=%0d arith=%b, need unf=1 tos=9 depth=1 arith=0",
                     err_unf, tos, depth, err_arith);
        end
    endtask

    task automatic test_overflow();
        int lat;
        apply_reset();
        for (int i = 0; i < D; i++) do_op(PUSH, 8'(i + 20), lat);
        tests++;
        if ({depth, tos, err_ovf} !== {5'd16, 8'd35, 1'b0}) begin
            fails++;
            $display("[TB] FAIL fill: got depth=%0d tos=%0d ovf=%b, need depth=16 tos=35 ovf=0", depth, tos, err_ovf);
        end
        do_op(PUSH, 8'd1, lat);
        tests++;
        if ({depth, tos, nos, err_ovf} !== {5'd16, 8'd35, 8'd34, 1'b1}) begin
            fails++;
            $display("[TB] FAIL push_full: got depth=%0d tos=%0d nos=%0d ovf=%b, need depth=16 tos=35 nos=34 ovf=1",
                     depth, tos, nos, err_ovf);
        end
        pulse_clr();
        do_op(DUP, 8'd0, lat);
        tests++;
        if ({depth, tos, err_ovf, err_unf} !== {5'd16, 8'd35, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL dup_full: got depth=%0d tos=%0d ovf=%b unf=%b, need depth=16 tos=35 ovf=1 unf=0",
                     depth, tos, err_ovf, err_unf);
        end
    endtask

    task automatic test_swap_reset();
        int lat;
        apply_reset();
        do_op(PUSH, 8'd4, lat);
        do_op(PUSH, 8'd6, lat);
        do_op(SWAP, 8'd0, lat);
        tests++;
        if ({tos, nos, depth} !== {8'd4, 8'd6, 5'd2}) begin
            fails++;
            $display("[TB] FAIL swap: got tos=%0d nos=%0d depth=%0d, need tos=4 nos=6 depth=2", tos, nos, depth);
        end
        op = PUSH; din = 8'd77; op_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        op_valid = 1'b0;
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1;
        tests++;
        if ({depth, tos, done, op_ready} !== {5'd0, 8'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset_mid_op: got depth=%0d tos=%0d done=%b ready=%b, need depth=0 tos=0 done=0 ready=1",
                     depth, tos, done, op_ready);
        end
        repeat (3) @(negedge CLOCK_50);
        tests++;
        if ({done, depth} !== {1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL reset_hold: got done=%b depth=%0d, need done=0 depth=0", done, depth);
        end
        RESET_N = 1'b1;
        m_stack.delete();
        m_ovf = 0; m_unf = 0; m_arith = 0;
    endtask

    task automatic test_random();
        int lat;
        logic [2:0] o;
        logic [7:0] d;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) pulse_clr();
            o = ($urandom_range(0, 3) == 0) ? PUSH : 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            do_op(o, d, lat);
            model_op(o, d);
            tests++;
            if (lat !== 3 || {tos, nos, depth, err_ovf, err_unf, err_arith} !== model_vec()) begin
                fails++;
                $display("[TB] FAIL random_%0d op=%0d din=%0d: got lat=%0d state=%h, need lat=3 state=%h",
                         i, o, d, lat, {tos, nos, depth, err_ovf, err_unf, err_arith}, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_arith_overflow();
        test_sub_borrow();
        test_underflow();
        test_overflow();
        test_swap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
